usb_tx_sched: RTL and testbench
===============================

# usb_tx_sched

Transmit packet scheduler for the USB full-speed TX path. It arbitrates between a handshake source and a data-packet source, and serializes each granted packet LSB-first into the bit-stuffer's pull interface. Each packet is SYNC, then PID, then payload, then an optional CRC16. After each packet the block enforces an inter-packet gap so the stuffer can finish EOP before the next packet starts. It sits between the endpoint logic and the bit-stuff/NRZI stage.

## Interface
Parameters:
- LEN_W, 7: width of the data-packet byte count (max payload 2^LEN_W-1 bytes).
- GAP_CYCLES, 16: cycles that `st_d_empty` is held high after the last bit, before the next grant (must be ≥ 8 and < 256).

Ports:
- `c`  in  1  clock.
- `rst_n`  in  1  reset. One clock; reset is asynchronous and active-low.
- `hs_req`  in  1  handshake packet request; level, held until `hs_ack`.
- `hs_pid`  in  4  handshake PID nibble; sampled at grant.
- `hs_ack`  out  1  one-cycle grant pulse for the handshake source.
- `dp_req`  in  1  data packet request; level, held until `dp_ack`.
- `dp_pid`  in  4  data PID nibble; sampled at grant.
- `dp_len`  in  LEN_W  payload byte count; sampled at grant; 0 is legal.
- `dp_ack`  out  1  one-cycle grant pulse for the data source.
- `dp_byte`  in  8  current payload byte; valid whenever `dp_req` is high.
- `dp_byte_req`  out  1  one-cycle pulse when `dp_byte` is latched; the source presents the next byte on the following cycle.
- `st_d`  out  1  serial bit to the stuffer.
- `st_d_empty`  out  1  high = no bit available (packet end or idle).
- `st_d_req`  in  1  stuffer consumed `st_d` this cycle.
- `busy`  out  1  high from grant through the end of the gap.
- `done`  out  1  one-cycle pulse on the last gap cycle.

## Operation
- States: IDLE, SYNC, PID, DATA, CRC, GAP.
- IDLE:
  - `hs_req` has priority over `dp_req`. Requests are only evaluated in IDLE.
  - On grant: pulse the matching ack, latch the PID byte {~pid, pid} into the shift register and the length, then go to SYNC.
- SYNC: shifts 0x80 LSB-first (seven 0s, then a 1).
- PID: shifts the latched PID byte.
- Exit from PID:
  - Handshake packets go to GAP.
  - Data packets with len > 0 go to DATA.
  - Data packets with len = 0 go to CRC, or to GAP when CRC is compiled out.
- DATA:
  - At each byte boundary, latch `dp_byte`, pulse `dp_byte_req`, and decrement the byte count.
  - When the count reaches 0 after the last bit, go to CRC, or to GAP when CRC is compiled out.
- CRC: shifts the 16-bit inverted CRC, low bit first.
- GAP:
  - `st_d_empty`=1 for exactly GAP_CYCLES cycles.
  - `done` pulses on the final cycle, then the block returns to IDLE.
- Bit advance:
  - Only on `st_d_req`=1 while `st_d_empty`=0. A 3-bit bit counter tracks position within the byte.
  - `st_d_req` while `st_d_empty`=1 is ignored.
- `st_d_empty`=0 in SYNC, PID, DATA and CRC; 1 in IDLE and GAP.
- Reset values (all outputs, also on reset mid-packet):
  - `st_d_empty`=1, `st_d`=0.
  - `hs_ack`, `dp_ack`, `dp_byte_req`, `busy`, `done` = 0.
  - State returns to IDLE, and the gap is not enforced.

## Timing
- Grant cycle N: ack is high in N, and `st_d_empty` falls in N+1 with `st_d`=0, the first SYNC bit.
- `st_d` is registered. It changes the cycle after an accepted `st_d_req` and stays stable while `st_d_req`=0, for any stall length.
- `st_d_req` on the last CRC or PID bit: `st_d_empty`=1 on the next cycle, with no bubble bit.
- `dp_byte_req` is high in the same cycle the first bit of that byte is loaded. There are no idle cycles between bytes.
- `busy` rises in N+1 and falls after `done`. A new grant is possible the cycle after `done`.
- Back-to-back `st_d_req` every cycle is supported at full rate.

## Configuration
- `USB_TX_CRC16_EN` defined:
  - Serial CRC16 is computed over payload bits: polynomial 0x8005, reflected, init 0xFFFF, output inverted.
  - The CRC is appended to data packets only.
- Undefined:
  - The CRC state is skipped and the CRC logic is absent.
  - Sources must supply their own CRC bytes inside `dp_len`.

## Structure
- Package `usb_tx_pkg`:
  - state enum;
  - SYNC_BYTE = 8'h80;
  - PID nibbles ACK = 4'h2, NAK = 4'hA, STALL = 4'hE, DATA0 = 4'h3, DATA1 = 4'hB;
  - CRC16_POLY = 16'h8005, CRC16_INIT = 16'hFFFF.
- Sub-module `usb_crc16_serial`: `c`, `rst_n`, `init`, `en`, `d` → `crc[15:0]`. It is used only under the macro.

## Test plan
- Handshake ACK (`hs_pid`=4'h2), `st_d_req` every cycle → `st_d` = 0,0,0,0,0,0,0,1, then 0,1,0,0,1,0,1,1 (0xD2); then `st_d_empty`=1 for 16 cycles; `done` pulses once.
- Zero-length DATA0 (`dp_pid`=3, `dp_len`=0), CRC on → SYNC, 0xC3, then 16 zero bits (CRC 0x0000); `dp_byte_req` never pulses.
- `dp_len`=9, bytes "123456789" (0x31..0x39), CRC on → payload followed by 0xC8 then 0xB4, LSB-first; nine `dp_byte_req` pulses.
- `hs_req` and `dp_req` raised in the same cycle → `hs_ack` first; `dp_ack` exactly 1 cycle after `done`.
- Hold `st_d_req`=0 for 10 cycles mid-DATA → `st_d` and the bit position are unchanged; the stream resumes without a lost or duplicated bit.
- Assert `rst_n`=0 mid-DATA → in the same cycle, `st_d_empty`=1 and `busy`=0; after release the next request restarts at SYNC.

Source files
------------

// File: rtl/usb_tx_pkg.sv
// rtl/usb_tx_pkg.sv - shared types and constants for the USB FS TX scheduler
package usb_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_PID,
    ST_DATA,
    ST_CRC,
    ST_GAP
  } state_e;

  localparam logic [7:0]  SYNC_BYTE  = 8'h80;

  localparam logic [3:0]  PID_ACK    = 4'h2;
  localparam logic [3:0]  PID_NAK    = 4'hA;
  localparam logic [3:0]  PID_STALL  = 4'hE;
  localparam logic [3:0]  PID_DATA0  = 4'h3;
  localparam logic [3:0]  PID_DATA1  = 4'hB;

  localparam logic [15:0] CRC16_POLY = 16'h8005;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  // Bit-reverse a 16-bit word; the serial CRC shifts right, so it needs the mirrored polynomial.
  function automatic logic [15:0] reflect16(input logic [15:0] v);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) begin
      r[i] = v[15-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/usb_tx_sched_if.sv
// rtl/usb_tx_sched_if.sv - request, payload and stuffer-pull signals of the TX scheduler
interface usb_tx_sched_if #(
  parameter int LEN_W = 7
);
  logic             hs_req;
  logic [3:0]       hs_pid;
  logic             hs_ack;
  logic             dp_req;
  logic [3:0]       dp_pid;
  logic [LEN_W-1:0] dp_len;
  logic             dp_ack;
  logic [7:0]       dp_byte;
  logic             dp_byte_req;
  logic             st_d;
  logic             st_d_empty;
  logic             st_d_req;
  logic             busy;
  logic             done;

  modport slave (
    input  hs_req, hs_pid, dp_req, dp_pid, dp_len, dp_byte, st_d_req,
    output hs_ack, dp_ack, dp_byte_req, st_d, st_d_empty, busy, done
  );

  modport master (
    output hs_req, hs_pid, dp_req, dp_pid, dp_len, dp_byte, st_d_req,
    input  hs_ack, dp_ack, dp_byte_req, st_d, st_d_empty, busy, done
  );
endinterface

// File: rtl/usb_crc16_serial.sv
// rtl/usb_crc16_serial.sv - bit-serial reflected CRC16 accumulator
module usb_crc16_serial
  import usb_tx_pkg::*;
(
  input  logic        c,
  input  logic        rst_n,
  input  logic        init,
  input  logic        en,
  input  logic        d,
  output logic [15:0] crc
);

  localparam logic [15:0] POLY_R = reflect16(CRC16_POLY);

  logic [15:0] crc_q, crc_d;
  logic        fb;

  // Next CRC: reload on init, otherwise fold in one payload bit (LSB-first order).
  always_comb begin
    crc_d = crc_q;
    fb    = crc_q[0] ^ d;
    if (init) begin
      crc_d = CRC16_INIT;
    end else if (en) begin
      crc_d = (crc_q >> 1) ^ (fb ? POLY_R : 16'h0000);
    end
  end

  // CRC register.
  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      crc_q <= CRC16_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/usb_tx_sched.sv
// rtl/usb_tx_sched.sv - USB FS TX packet scheduler/serializer; CRC16 append under USB_TX_CRC16_EN
module usb_tx_sched
  import usb_tx_pkg::*;
#(
  parameter int LEN_W      = 7,
  parameter int GAP_CYCLES = 16
) (
  input  logic          c,
  input  logic          rst_n,
  usb_tx_sched_if.slave bus
);

  localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

  state_e           state_q, state_d;
  logic [7:0]       sr_q, sr_d;
  logic [2:0]       bit_q, bit_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             is_hs_q, is_hs_d;
  logic             st_d_q, st_d_d;
  logic [7:0]       gap_q, gap_d;

  logic             hs_ack, dp_ack, dp_byte_req;
  logic             empty, adv, last_bit;

`ifdef USB_TX_CRC16_EN
  logic             crc_hi_q, crc_hi_d;
  logic             crc_init;
  logic [15:0]      crc;
`endif

  assign empty    = (state_q == ST_IDLE) || (state_q == ST_GAP);
  assign adv      = bus.st_d_req && !empty;
  assign last_bit = (bit_q == 3'd7);

  // Arbitration, bit sequencing and byte/segment transitions.
  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    bit_d       = bit_q;
    len_d       = len_q;
    is_hs_d     = is_hs_q;
    st_d_d      = st_d_q;
    gap_d       = gap_q;
    hs_ack      = 1'b0;
    dp_ack      = 1'b0;
    dp_byte_req = 1'b0;
`ifdef USB_TX_CRC16_EN
    crc_hi_d    = crc_hi_q;
    crc_init    = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.hs_req) begin
          hs_ack  = 1'b1;
          is_hs_d = 1'b1;
          sr_d    = {~bus.hs_pid, bus.hs_pid};
        end else if (bus.dp_req) begin
          dp_ack  = 1'b1;
          is_hs_d = 1'b0;
          sr_d    = {~bus.dp_pid, bus.dp_pid};
          len_d   = bus.dp_len;
        end
        if (bus.hs_req || bus.dp_req) begin
          state_d = ST_SYNC;
          bit_d   = 3'd0;
          st_d_d  = SYNC_BYTE[0];
`ifdef USB_TX_CRC16_EN
          crc_init = 1'b1;
`endif
        end
      end
      ST_SYNC: begin
        if (adv) begin
          bit_d = bit_q + 3'd1;
          if (last_bit) begin
            state_d = ST_PID;
            st_d_d  = sr_q[0];
          end else begin
            st_d_d  = SYNC_BYTE[3'(bit_q + 3'd1)];
          end
        end
      end
      ST_PID, ST_DATA: begin
        if (adv) begin
          bit_d  = bit_q + 3'd1;
          sr_d   = sr_q >> 1;
          st_d_d = sr_q[1];
          if (last_bit) begin
            if (!is_hs_q && len_q != '0) begin
              // Next payload byte goes straight out behind the current one.
              sr_d        = bus.dp_byte;
              st_d_d      = bus.dp_byte[0];
              len_d       = len_q - LEN_W'(1);
              dp_byte_req = 1'b1;
              state_d     = ST_DATA;
            end else if (!is_hs_q) begin
`ifdef USB_TX_CRC16_EN
              state_d  = ST_CRC;
              crc_hi_d = 1'b0;
              st_d_d   = 1'b0;
`else
              state_d  = ST_GAP;
              gap_d    = 8'd0;
              st_d_d   = 1'b0;
`endif
            end else begin
              state_d = ST_GAP;
              gap_d   = 8'd0;
              st_d_d  = 1'b0;
            end
          end
        end
      end
`ifdef USB_TX_CRC16_EN
      ST_CRC: begin
        if (adv) begin
          bit_d = bit_q + 3'd1;
          if (last_bit) begin
            if (!crc_hi_q) begin
              crc_hi_d = 1'b1;
            end else begin
              state_d = ST_GAP;
              gap_d   = 8'd0;
              st_d_d  = 1'b0;
            end
          end
        end
      end
`endif
      ST_GAP: begin
        gap_d = gap_q + 8'd1;
        if (gap_q == GAP_LAST) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops any packet in flight and skips the gap.
  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      sr_q     <= 8'h00;
      bit_q    <= 3'd0;
      len_q    <= '0;
      is_hs_q  <= 1'b0;
      st_d_q   <= 1'b0;
      gap_q    <= 8'd0;
`ifdef USB_TX_CRC16_EN
      crc_hi_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      bit_q    <= bit_d;
      len_q    <= len_d;
      is_hs_q  <= is_hs_d;
      st_d_q   <= st_d_d;
      gap_q    <= gap_d;
`ifdef USB_TX_CRC16_EN
      crc_hi_q <= crc_hi_d;
`endif
    end
  end

`ifdef USB_TX_CRC16_EN
  usb_crc16_serial u_crc (
    .c     (c),
    .rst_n (rst_n),
    .init  (crc_init),
    .en    (adv && (state_q == ST_DATA)),
    .d     (st_d_q),
    .crc   (crc)
  );

  // The CRC is frozen once DATA ends, so its bits are read out in place.
  assign bus.st_d = (state_q == ST_CRC) ? ~crc[{crc_hi_q, bit_q}] : st_d_q;
`else
  assign bus.st_d = st_d_q;
`endif

  assign bus.hs_ack      = hs_ack;
  assign bus.dp_ack      = dp_ack;
  assign bus.dp_byte_req = dp_byte_req;
  assign bus.st_d_empty  = empty;
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.done        = (state_q == ST_GAP) && (gap_q == GAP_LAST);

endmodule

// File: tb/tb_usb_tx_sched.sv
// tb/tb_usb_tx_sched.sv - randomized self-checking bench for usb_tx_sched
module tb_usb_tx_sched;

  localparam int LEN_W = 7;
  localparam int GAP   = 16;
`ifdef USB_TX_CRC16_EN
  localparam bit CRC_ON = 1'b1;
`else
  localparam bit CRC_ON = 1'b0;
`endif

  logic c = 1'b0;
  logic rst_n = 1'b0;
  always #5 c = ~c;

  usb_tx_sched_if #(.LEN_W(LEN_W)) bus ();

  usb_tx_sched #(.LEN_W(LEN_W), .GAP_CYCLES(GAP)) dut (
    .c     (c),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_fail = 0;

  bit         exp_q[$];
  bit         got_q[$];
  logic [7:0] pay[$];
  int         pay_idx;
  int         mode;
  int         cyc = 0;

  bit         want_hs, want_dp;
  logic [3:0] want_hs_pid, want_dp_pid;

  logic s_hs_ack, s_dp_ack, s_br, s_st_d, s_empty, s_busy, s_done;
  int   cnt_br, cnt_done, gap_cyc;
  int   hs_ack_cyc, dp_ack_cyc, first_done_cyc, first_bit_cyc, last_bit_cyc;
  logic first_bit_val;
  bit   timed_out;

  task automatic clear_stats();
    got_q.delete();
    exp_q.delete();
    s_hs_ack = 0; s_dp_ack = 0; s_br = 0; s_st_d = 0; s_empty = 1; s_busy = 0; s_done = 0;
    cnt_br = 0; cnt_done = 0; gap_cyc = 0;
    hs_ack_cyc = -1; dp_ack_cyc = -1; first_done_cyc = -1; first_bit_cyc = -1; last_bit_cyc = -1;
    first_bit_val = 1'bx;
    timed_out = 0;
  endtask

  // Reference wire format: SYNC, PID byte, payload, then inverted CRC16 of the payload for data packets.
  task automatic add_exp(input bit is_hs, input logic [3:0] pid);
    logic [7:0]  b;
    logic [15:0] crc;
    bit          x, fb;
    b = 8'h80;
    for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
    b = {~pid, pid};
    for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
    if (!is_hs) begin
      crc = 16'hFFFF;
      foreach (pay[k]) begin
        b = pay[k];
        for (int i = 0; i < 8; i++) begin
          x = b[i];
          exp_q.push_back(x);
          fb  = crc[0] ^ x;
          crc = crc >> 1;
          if (fb) crc = crc ^ 16'hA001;
        end
      end
      if (CRC_ON) begin
        crc = ~crc;
        for (int i = 0; i < 16; i++) exp_q.push_back(crc[i]);
      end
    end
  endtask

  function automatic int stream_diff();
    if (got_q.size() != exp_q.size()) return -2;
    foreach (exp_q[i]) if (got_q[i] !== exp_q[i]) return i;
    return -1;
  endfunction

  // One clock: drive sources and the stuffer pull at negedge, sample 1 ns later.
  task automatic step();
    @(negedge c);
    if (s_hs_ack) bus.hs_req = 1'b0;
    if (s_dp_ack) bus.dp_req = 1'b0;
    if (s_br) begin
      pay_idx++;
      bus.dp_byte = (pay_idx < pay.size()) ? pay[pay_idx] : 8'($urandom);
    end
    if (want_hs) begin
      bus.hs_req = 1'b1;
      bus.hs_pid = want_hs_pid;
      want_hs = 0;
    end
    if (want_dp) begin
      bus.dp_req  = 1'b1;
      bus.dp_pid  = want_dp_pid;
      bus.dp_len  = LEN_W'(pay.size());
      pay_idx     = 0;
      bus.dp_byte = (pay.size() > 0) ? pay[0] : 8'h00;
      want_dp = 0;
    end
    case (mode)
      0:       bus.st_d_req = 1'b1;
      1:       bus.st_d_req = ($urandom_range(0, 3) != 0);
      default: bus.st_d_req = 1'b0;
    endcase
    #1;
    cyc++;
    s_hs_ack = bus.hs_ack;
    s_dp_ack = bus.dp_ack;
    s_br     = bus.dp_byte_req;
    s_st_d   = bus.st_d;
    s_empty  = bus.st_d_empty;
    s_busy   = bus.busy;
    s_done   = bus.done;
    if (bus.st_d_req && !s_empty) begin
      got_q.push_back(s_st_d);
      last_bit_cyc = cyc;
      if (first_bit_cyc < 0) begin
        first_bit_cyc = cyc;
        first_bit_val = s_st_d;
      end
    end
    if (s_br) cnt_br++;
    if (s_hs_ack && hs_ack_cyc < 0) hs_ack_cyc = cyc;
    if (s_dp_ack && dp_ack_cyc < 0) dp_ack_cyc = cyc;
    if (s_done) begin
      cnt_done++;
      if (first_done_cyc < 0) first_done_cyc = cyc;
    end
    if (s_empty && s_busy) gap_cyc++;
  endtask

  task automatic run_until(input int target, input int budget);
    for (int i = 0; i < budget && cnt_done < target; i++) step();
    if (cnt_done < target) timed_out = 1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge c);
    #1;
    n_chk++;
    if (bus.st_d_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b expected 1", bus.st_d_empty); end
    n_chk++;
    if (bus.st_d !== 1'b0) begin n_fail++; $display("FAIL reset_st_d: got %b expected 0", bus.st_d); end
    n_chk++;
    if ({bus.hs_ack, bus.dp_ack, bus.dp_byte_req, bus.busy, bus.done} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected 00000", {bus.hs_ack, bus.dp_ack, bus.dp_byte_req, bus.busy, bus.done});
    end
    @(negedge c);
    rst_n = 1'b1;
  endtask

  task automatic test_hs_ack();
    clear_stats();
    pay.delete();
    add_exp(1'b1, 4'h2);
    want_hs = 1; want_hs_pid = 4'h2; mode = 0;
    run_until(1, 300);
    n_chk++;
    if (timed_out) begin n_fail++; $display("FAIL hs_timeout: got done=%0d expected 1", cnt_done); end
    n_chk++;
    if (stream_diff() != -1) begin n_fail++; $display("FAIL hs_stream: got diff at %0d (%0d bits) expected %0d bits", stream_diff(), got_q.size(), exp_q.size()); end
    n_chk++;
    if (first_bit_cyc !== hs_ack_cyc + 1 || first_bit_val !== 1'b0) begin
      n_fail++; $display("FAIL hs_first_bit: got cyc %0d val %b expected cyc %0d val 0", first_bit_cyc, first_bit_val, hs_ack_cyc + 1);
    end
    n_chk++;
    if (gap_cyc !== GAP) begin n_fail++; $display("FAIL hs_gap: got %0d expected %0d", gap_cyc, GAP); end
    n_chk++;
    if (first_done_cyc !== last_bit_cyc + GAP) begin n_fail++; $display("FAIL hs_done_time: got %0d expected %0d", first_done_cyc, last_bit_cyc + GAP); end
    n_chk++;
    if (cnt_br !== 0) begin n_fail++; $display("FAIL hs_byte_req: got %0d expected 0", cnt_br); end
  endtask

  task automatic test_zero_len();
    clear_stats();
    pay.delete();
    add_exp(1'b0, 4'h3);
    want_dp = 1; want_dp_pid = 4'h3; mode = 0;
    run_until(1, 300);
    n_chk++;
    if (timed_out || stream_diff() != -1) begin n_fail++; $display("FAIL zlen_stream: got diff at %0d (%0d bits) expected %0d bits", stream_diff(), got_q.size(), exp_q.size()); end
    n_chk++;
    if (cnt_br !== 0) begin n_fail++; $display("FAIL zlen_byte_req: got %0d expected 0", cnt_br); end
    n_chk++;
    if (gap_cyc !== GAP) begin n_fail++; $display("FAIL zlen_gap: got %0d expected %0d", gap_cyc, GAP); end
  endtask

  task automatic test_crc_vector();
    logic [15:0] tail;
    clear_stats();
    pay.delete();
    for (int i = 0; i < 9; i++) pay.push_back(8'(8'h31 + i));
    add_exp(1'b0, 4'hB);
    want_dp = 1; want_dp_pid = 4'hB; mode = 0;
    run_until(1, 500);
    n_chk++;
    if (timed_out || stream_diff() != -1) begin n_fail++; $display("FAIL vec_stream: got diff at %0d (%0d bits) expected %0d bits", stream_diff(), got_q.size(), exp_q.size()); end
    n_chk++;
    if (cnt_br !== 9) begin n_fail++; $display("FAIL vec_byte_req: got %0d expected 9", cnt_br); end
`ifdef USB_TX_CRC16_EN
    tail = 16'h0;
    if (got_q.size() >= 16) for (int i = 0; i < 16; i++) tail[i] = got_q[got_q.size() - 16 + i];
    n_chk++;
    if (tail !== 16'hB4C8) begin n_fail++; $display("FAIL vec_crc: got %h expected b4c8", tail); end
`else
    tail = 16'h0;
`endif
  endtask

  task automatic test_priority();
    int start;
    clear_stats();
    pay.delete();
    for (int i = 0; i < 3; i++) pay.push_back(8'($urandom));
    add_exp(1'b1, 4'hA);
    add_exp(1'b0, 4'hB);
    want_hs = 1; want_hs_pid = 4'hA;
    want_dp = 1; want_dp_pid = 4'hB;
    mode = 0;
    start = cyc + 1;
    run_until(2, 800);
    n_chk++;
    if (hs_ack_cyc !== start) begin n_fail++; $display("FAIL prio_hs_ack: got cyc %0d expected %0d", hs_ack_cyc, start); end
    n_chk++;
    if (dp_ack_cyc !== first_done_cyc + 1) begin n_fail++; $display("FAIL prio_dp_ack: got cyc %0d expected %0d", dp_ack_cyc, first_done_cyc + 1); end
    n_chk++;
    if (timed_out || stream_diff() != -1) begin n_fail++; $display("FAIL prio_stream: got diff at %0d (%0d bits) expected %0d bits", stream_diff(), got_q.size(), exp_q.size()); end
  endtask

  task automatic test_stall();
    logic st0;
    int   nbits;
    clear_stats();
    pay.delete();
    for (int i = 0; i < 6; i++) pay.push_back(8'($urandom));
    add_exp(1'b0, 4'h3);
    want_dp = 1; want_dp_pid = 4'h3; mode = 0;
    for (int i = 0; i < 200 && cnt_br < 3; i++) step();
    repeat (3) step();
    mode = 2;
    step();
    st0   = s_st_d;
    nbits = got_q.size();
    for (int i = 0; i < 10; i++) begin
      step();
      n_chk++;
      if (s_st_d !== st0 || s_empty !== 1'b0) begin
        n_fail++; $display("FAIL stall_hold: got st_d %b empty %b expected st_d %b empty 0", s_st_d, s_empty, st0);
      end
    end
    n_chk++;
    if (got_q.size() !== nbits) begin n_fail++; $display("FAIL stall_bits: got %0d expected %0d", got_q.size(), nbits); end
    mode = 0;
    run_until(1, 500);
    n_chk++;
    if (timed_out || stream_diff() != -1) begin n_fail++; $display("FAIL stall_stream: got diff at %0d (%0d bits) expected %0d bits", stream_diff(), got_q.size(), exp_q.size()); end
  endtask

  task automatic test_random();
    bit         is_hs;
    logic [3:0] pid;
    int         len;
    for (int p = 0; p < 8; p++) begin
      clear_stats();
      pay.delete();
      is_hs = ($urandom_range(0, 2) == 0);
      pid   = 4'($urandom);
      len   = is_hs ? 0 : $urandom_range(0, 12);
      for (int i = 0; i < len; i++) pay.push_back(8'($urandom));
      add_exp(is_hs, pid);
      if (is_hs) begin want_hs = 1; want_hs_pid = pid; end
      else       begin want_dp = 1; want_dp_pid = pid; end
      mode = 1;
      run_until(1, 1500);
      n_chk++;
      if (timed_out || stream_diff() != -1) begin n_fail++; $display("FAIL rand_stream[%0d]: got diff at %0d (%0d bits) expected %0d bits", p, stream_diff(), got_q.size(), exp_q.size()); end
      n_chk++;
      if (cnt_br !== len) begin n_fail++; $display("FAIL rand_byte_req[%0d]: got %0d expected %0d", p, cnt_br, len); end
      n_chk++;
      if (gap_cyc !== GAP || first_done_cyc !== last_bit_cyc + GAP) begin
        n_fail++; $display("FAIL rand_gap[%0d]: got gap %0d done %0d expected gap %0d done %0d", p, gap_cyc, first_done_cyc, GAP, last_bit_cyc + GAP);
      end
    end
  endtask

  task automatic test_reset_mid();
    clear_stats();
    pay.delete();
    for (int i = 0; i < 20; i++) pay.push_back(8'($urandom));
    want_dp = 1; want_dp_pid = 4'h3; mode = 0;
    for (int i = 0; i < 200 && cnt_br < 2; i++) step();
    @(negedge c);
    rst_n = 1'b0;
    bus.dp_req = 1'b0;
    bus.hs_req = 1'b0;
    #1;
    n_chk++;
    if (bus.st_d_empty !== 1'b1 || bus.busy !== 1'b0 || bus.st_d !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset: got empty %b busy %b st_d %b expected 1 0 0", bus.st_d_empty, bus.busy, bus.st_d);
    end
    @(negedge c);
    rst_n = 1'b1;
    clear_stats();
    pay.delete();
    add_exp(1'b1, 4'hA);
    want_hs = 1; want_hs_pid = 4'hA; mode = 1;
    run_until(1, 500);
    n_chk++;
    if (timed_out || stream_diff() != -1) begin n_fail++; $display("FAIL mid_restart: got diff at %0d (%0d bits) expected %0d bits", stream_diff(), got_q.size(), exp_q.size()); end
  endtask

  initial begin
    bus.hs_req = 1'b0; bus.hs_pid = 4'h0;
    bus.dp_req = 1'b0; bus.dp_pid = 4'h0; bus.dp_len = '0; bus.dp_byte = 8'h00;
    bus.st_d_req = 1'b0;
    want_hs = 0; want_dp = 0; mode = 0; pay_idx = 0;
    clear_stats();
    test_reset();
    test_hs_ack();
    test_zero_len();
    test_crc_vector();
    test_priority();
    test_stall();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
